bullet_hit_scanner: RTL and testbench
=====================================

// Module: bullet_hit_scanner
// PURPOSE
// - Downstream consumer of the bullet table. Once per frame tick, walks all 8 bullet slots through the table's second read port.
// - Tests each live bullet's box against the player box and applies damage or heal to player HP.
// - Pulses is_collide so the table clears the hit slot.
// - Sits between the bullet table and HP display / game-state logic.
// PARAMETERS
// - N_BULLETS      8   slots scanned; index width 3
// - HP_MAX         20  HP reset value and heal ceiling
// - DAMAGE         1   HP removed per damaging hit
// - HEAL           1   HP added per green hit
// - INVULN_TICKS   2   frame ticks after a damaging hit during which damage is ignored
// PORTS
// - clk             in   1   system clock
// - rst_n           in   1   asynchronous active-low reset
// - tick            in   1   frame strobe, 1 cycle wide; starts a scan
// - player_pos      in   16  [15:8]=X, [7:0]=Y of player box top-left
// - player_size     in   16  [15:8]=W, [7:0]=H
// - player_moving   in   1   player moved this frame
// - bullet_index    out  3   slot address driven to the table's second read port
// - bullet_pos      in   16  slot X/Y, same packing as player_pos; valid same cycle as bullet_index
// - bullet_size     in   16  slot W/H, same packing as player_size
// - bullet_color    in   3   000 white, 001 green, 010 blue, others inert
// - bullet_render   in   1   slot live
// - is_collide      out  1   1-cycle pulse; the table clears slot bullet_index
// - hp              out  8   current HP
// - hit_pulse       out  1   1 cycle when HP decremented
// - game_over       out  1   sticky once hp reaches 0
// - busy            out  1   scan in progress
// BEHAVIOUR
// - Reset values: bullet_index=0, is_collide=0, hp=HP_MAX, hit_pulse=0, game_over=0, busy=0, invuln counter=0, pending=0.
// - FSM states: IDLE, ADDR, CHECK, HIT, DONE.
// - IDLE: on tick, or on pending set, go to ADDR with idx=0. Clear pending. Set busy.
// - ADDR: drive bullet_index=idx for one settle cycle.
// - CHECK: sample inputs and evaluate the hit.
//   - Overlap uses 9-bit sums, so no 8-bit wrap: bx<px+pw && px<bx+bw && by<py+ph && py<by+bh.
//   - Edges that only touch do not overlap.
//   - If bullet_render && overlap && color in {000,001,010}, go to HIT. Otherwise advance.
// - HIT: is_collide=1 for exactly this cycle, bullet_index held at idx. Then advance.
//   - white: damaging.
//   - blue: damaging only if player_moving; otherwise treated as no hit, and is_collide is not asserted.
//   - damaging and invuln==0: hp=max(hp-DAMAGE,0), hit_pulse=1, invuln=INVULN_TICKS.
//   - damaging and invuln!=0: slot still cleared (is_collide=1), hp unchanged, no hit_pulse.
//   - green: hp=min(hp+HEAL,HP_MAX). Applies regardless of invuln.
// - Advance: if idx==N_BULLETS-1 go to DONE, else idx+1 and go to ADDR.
// - DONE: busy=0, go to IDLE.
// - Scan latency: 2 cycles per slot, +1 per hit. Worst case 2*8+8+1=25 cycles.
// - tick while busy: latch pending; at most one is held and extra ticks are dropped. The scan is never restarted mid-way.
// - invuln decrements by 1 on each tick, saturating at 0.
// - hp==0: game_over=1. FSM forced to IDLE after the current HIT. Further ticks ignored until rst_n.
// - Reset mid-scan: all state returns to reset values immediately. No is_collide pulse is emitted.
// STRUCTURE
// - Shared package:
//   - color codes COL_WHITE=3'b000, COL_GREEN=3'b001, COL_BLUE=3'b010
//   - pos/size field slice constants
//   - FSM state enum
// - One sub-module, aabb_overlap: combinational 9-bit box-overlap compare. Reused later for player-vs-wall checks.
// TESTING
// - Reset: after rst_n release: hp=20, game_over=0, busy=0, is_collide=0, bullet_index=0.
// - Single hit:
//   - Setup: slot0 white live at (40,40) 16x16; player (45,45) 10x10; others not live.
//   - Stimulus: tick.
//   - Response: one is_collide pulse with bullet_index=0, hp=19, hit_pulse once, busy for 2*8+1+1 cycles.
// - Boundaries:
//   - Edge touch: bullet (40,40) 16x16, player X=56. No hit.
//   - Wrap: bullet X=250 W=16, player X=5. No hit.
// - Invuln and heal:
//   - Two white hits in consecutive ticks: hp 20->19 only, both slots cleared.
//   - Green hit at hp=20: stays 20.
//   - Blue hit with player_moving=0: no is_collide. With player_moving=1: hp decremented.
// - Death: hp=1 plus a white hit -> hp=0, game_over=1; next tick: busy stays 0.
// - Overlap/reset:
//   - tick pulsed during a scan: exactly one follow-on scan.
//   - rst_n asserted mid-scan: outputs at reset values and no is_collide until the next tick.

Source files
------------

// File: rtl/bullet_hit_scanner_pkg.sv
// Shared definitions for the bullet hit scanner: colour codes, box field slices,
// scan FSM states and a colour classification helper.
package bullet_hit_scanner_pkg;

   localparam int N_BULLETS = 8;
   localparam int IDX_W     = 3;

   localparam logic [2:0] COL_WHITE = 3'b000;
   localparam logic [2:0] COL_GREEN = 3'b001;
   localparam logic [2:0] COL_BLUE  = 3'b010;

   // pos packs X/Y and size packs W/H with the same byte layout
   localparam int X_MSB = 15;
   localparam int X_LSB = 8;
   localparam int Y_MSB = 7;
   localparam int Y_LSB = 0;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CHECK,
      HIT,
      DONE
   } scan_state_t;

   function automatic logic isActiveColor(input logic [2:0] color);
      return (color == COL_WHITE) || (color == COL_GREEN) || (color == COL_BLUE);
   endfunction

endpackage

// File: rtl/bullet_hit_scanner_aabb_overlap.sv
// Combinational axis-aligned box overlap test; right/bottom edges are computed
// in 9 bits so boxes near the 255 edge never wrap. Touching edges do not overlap.
module aabb_overlap
   import bullet_hit_scanner_pkg::*;
(
   input  logic [15:0] i_aPos,
   input  logic [15:0] i_aSize,
   input  logic [15:0] i_bPos,
   input  logic [15:0] i_bSize,
   output logic        o_overlap
);

   logic [8:0] w_aX;
   logic [8:0] w_aY;
   logic [8:0] w_aXEnd;
   logic [8:0] w_aYEnd;
   logic [8:0] w_bX;
   logic [8:0] w_bY;
   logic [8:0] w_bXEnd;
   logic [8:0] w_bYEnd;

   assign w_aX    = {1'b0, i_aPos[X_MSB:X_LSB]};
   assign w_aY    = {1'b0, i_aPos[Y_MSB:Y_LSB]};
   assign w_aXEnd = w_aX + {1'b0, i_aSize[X_MSB:X_LSB]};
   assign w_aYEnd = w_aY + {1'b0, i_aSize[Y_MSB:Y_LSB]};

   assign w_bX    = {1'b0, i_bPos[X_MSB:X_LSB]};
   assign w_bY    = {1'b0, i_bPos[Y_MSB:Y_LSB]};
   assign w_bXEnd = w_bX + {1'b0, i_bSize[X_MSB:X_LSB]};
   assign w_bYEnd = w_bY + {1'b0, i_bSize[Y_MSB:Y_LSB]};

   assign o_overlap = (w_aX < w_bXEnd) && (w_bX < w_aXEnd) &&
                      (w_aY < w_bYEnd) && (w_bY < w_aYEnd);

endmodule

// File: rtl/bullet_hit_scanner.sv
// Per-frame scan of the bullet table: tests every live bullet against the player
// box, applies damage/heal to HP and pulses is_collide so the table clears the slot.
module bullet_hit_scanner
   import bullet_hit_scanner_pkg::*;
#(
   parameter int HP_MAX       = 20,
   parameter int DAMAGE       = 1,
   parameter int HEAL         = 1,
   parameter int INVULN_TICKS = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [15:0]      player_pos,
   input  logic [15:0]      player_size,
   input  logic             player_moving,
   output logic [IDX_W-1:0] bullet_index,
   input  logic [15:0]      bullet_pos,
   input  logic [15:0]      bullet_size,
   input  logic [2:0]       bullet_color,
   input  logic             bullet_render,
   output logic             is_collide,
   output logic [7:0]       hp,
   output logic             hit_pulse,
   output logic             game_over,
   output logic             busy
);

   localparam logic [7:0]       L_HP_MAX   = 8'(HP_MAX);
   localparam logic [7:0]       L_DAMAGE   = 8'(DAMAGE);
   localparam logic [7:0]       L_HEAL     = 8'(HEAL);
   localparam logic [3:0]       L_INVULN   = 4'(INVULN_TICKS);
   localparam logic [IDX_W-1:0] L_LAST_IDX = IDX_W'(N_BULLETS - 1);

   scan_state_t      r_state;
   scan_state_t      w_nextState;
   logic [IDX_W-1:0] r_idx;
   logic             r_pending;
   logic [7:0]       r_hp;
   logic [3:0]       r_invuln;
   logic             r_gameOver;
   logic             r_hitPulse;
   logic [2:0]       r_color;
   logic             r_moving;

   logic w_overlap;
   logic w_start;
   logic w_lastSlot;
   logic w_damaging;
   logic w_healing;
   logic w_applyDamage;
   logic w_dies;

   aabb_overlap u_overlap (
      .i_aPos    (player_pos),
      .i_aSize   (player_size),
      .i_bPos    (bullet_pos),
      .i_bSize   (bullet_size),
      .o_overlap (w_overlap)
   );

   assign w_start       = (r_state == IDLE) && !r_gameOver && (tick || r_pending);
   assign w_lastSlot    = (r_idx == L_LAST_IDX);
   assign w_damaging    = (r_state == HIT) &&
                          ((r_color == COL_WHITE) || ((r_color == COL_BLUE) && r_moving));
   assign w_healing     = (r_state == HIT) && (r_color == COL_GREEN);
   assign w_applyDamage = w_damaging && (r_invuln == 4'd0);
   assign w_dies        = w_applyDamage && (r_hp <= L_DAMAGE);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:  if (w_start) w_nextState = ADDR;
         ADDR:  w_nextState = CHECK;
         CHECK: begin
            if (bullet_render && w_overlap && isActiveColor(bullet_color))
               w_nextState = HIT;
            else
               w_nextState = w_lastSlot ? DONE : ADDR;
         end
         // A fatal hit abandons the rest of the scan
         HIT: begin
            if (w_dies)
               w_nextState = IDLE;
            else
               w_nextState = w_lastSlot ? DONE : ADDR;
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_pending <= 1'b0;
         r_color   <= 3'b000;
         r_moving  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_start)
            r_idx <= '0;
         else if (((r_state == CHECK) || (r_state == HIT)) && (w_nextState == ADDR))
            r_idx <= r_idx + 1'b1;
         // Only one extra tick is remembered while a scan runs
         if (w_start)
            r_pending <= 1'b0;
         else if (tick && (r_state != IDLE))
            r_pending <= 1'b1;
         if (r_state == CHECK) begin
            r_color  <= bullet_color;
            r_moving <= player_moving;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hp       <= L_HP_MAX;
         r_invuln   <= 4'd0;
         r_gameOver <= 1'b0;
         r_hitPulse <= 1'b0;
      end else begin
         r_hitPulse <= 1'b0;
         if (w_applyDamage) begin
            r_invuln   <= L_INVULN;
            r_hitPulse <= 1'b1;
            r_hp       <= w_dies ? 8'd0 : (r_hp - L_DAMAGE);
            if (w_dies)
               r_gameOver <= 1'b1;
         end else begin
            if (tick && (r_invuln != 4'd0))
               r_invuln <= r_invuln - 1'b1;
            if (w_healing)
               r_hp <= (r_hp >= (L_HP_MAX - L_HEAL)) ? L_HP_MAX : (r_hp + L_HEAL);
         end
      end
   end

   assign bullet_index = r_idx;
   assign is_collide   = w_damaging || w_healing;
   assign hp           = r_hp;
   assign hit_pulse    = r_hitPulse;
   assign game_over    = r_gameOver;
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Testbench for bullet_hit_scanner: behavioural bullet table plus an HP/scan model;
// expected collide slots are queued per scan and popped as is_collide pulses appear.
module tb_bullet_hit_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic [15:0] player_pos = 16'h0000;
   logic [15:0] player_size = 16'h0000;
   logic        player_moving = 1'b0;
   logic [2:0]  bullet_index;
   logic [15:0] bullet_pos;
   logic [15:0] bullet_size;
   logic [2:0]  bullet_color;
   logic        bullet_render;
   logic        is_collide;
   logic [7:0]  hp;
   logic        hit_pulse;
   logic        game_over;
   logic        busy;

   logic [15:0] tblPos [8];
   logic [15:0] tblSize [8];
   logic [2:0]  tblColor [8];
   logic        tblRender [8];

   int expIdxQ[$];
   int modelHp;
   int modelInvuln;
   bit modelGameOver;
   int expBusy;
   int expPulses;

   int checkCount = 0;
   int passCount = 0;
   int busyCnt;
   int pulseCnt;
   int collideCnt;
   int busyRises;
   logic prevBusy = 1'b0;

   bullet_hit_scanner dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .player_pos    (player_pos),
      .player_size   (player_size),
      .player_moving (player_moving),
      .bullet_index  (bullet_index),
      .bullet_pos    (bullet_pos),
      .bullet_size   (bullet_size),
      .bullet_color  (bullet_color),
      .bullet_render (bullet_render),
      .is_collide    (is_collide),
      .hp            (hp),
      .hit_pulse     (hit_pulse),
      .game_over     (game_over),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // The bullet table's second read port answers in the same cycle
   assign bullet_pos    = tblPos[bullet_index];
   assign bullet_size   = tblSize[bullet_index];
   assign bullet_color  = tblColor[bullet_index];
   assign bullet_render = tblRender[bullet_index];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   // Advances one cycle and does the monitor work: scoreboard pops and table clears
   task automatic stepCycle();
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      if ((busy === 1'b1) && (prevBusy !== 1'b1)) busyRises++;
      prevBusy = busy;
      if (hit_pulse === 1'b1) pulseCnt++;
      if (is_collide === 1'b1) begin
         collideCnt++;
         if (expIdxQ.size() == 0)
            checkOutput("collide_unexpected", 32'(is_collide), 32'd0);
         else
            checkOutput("collide_idx", 32'(bullet_index), 32'(expIdxQ.pop_front()));
         tblRender[bullet_index] = 1'b0;
      end
   endtask

   task automatic clearTable();
      for (int i = 0; i < 8; i++) begin
         tblPos[i]    = 16'h0000;
         tblSize[i]   = 16'h0000;
         tblColor[i]  = 3'b111;
         tblRender[i] = 1'b0;
      end
   endtask

   task automatic loadSlot(input int idx, input int x, input int y, input int w, input int h, input int color);
      tblPos[idx]    = {8'(x), 8'(y)};
      tblSize[idx]   = {8'(w), 8'(h)};
      tblColor[idx]  = 3'(color);
      tblRender[idx] = 1'b1;
   endtask

   task automatic setPlayer(input int x, input int y, input int w, input int h);
      player_pos  = {8'(x), 8'(y)};
      player_size = {8'(w), 8'(h)};
   endtask

   function automatic bit boxHit(input int i);
      int bx, by, bw, bh, px, py, pw, ph;
      bx = int'(tblPos[i][15:8]);  by = int'(tblPos[i][7:0]);
      bw = int'(tblSize[i][15:8]); bh = int'(tblSize[i][7:0]);
      px = int'(player_pos[15:8]); py = int'(player_pos[7:0]);
      pw = int'(player_size[15:8]); ph = int'(player_size[7:0]);
      return (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
   endfunction

   task automatic modelTick();
      if (modelInvuln > 0) modelInvuln--;
   endtask

   task automatic modelScan();
      int lastIdx;
      int nHit;
      bit died;
      lastIdx = 7;
      nHit = 0;
      died = 1'b0;
      expPulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (tblRender[i] && boxHit(i) && (tblColor[i] <= 3'd2)) begin
            nHit++;
            if (tblColor[i] == 3'd1) begin
               expIdxQ.push_back(i);
               modelHp = (modelHp + 1 > 20) ? 20 : modelHp + 1;
            end else if ((tblColor[i] == 3'd0) || player_moving) begin
               expIdxQ.push_back(i);
               if (modelInvuln == 0) begin
                  modelHp = (modelHp > 1) ? modelHp - 1 : 0;
                  modelInvuln = 2;
                  expPulses++;
                  if (modelHp == 0) begin
                     modelGameOver = 1'b1;
                     died = 1'b1;
                     lastIdx = i;
                     break;
                  end
               end
            end
         end
      end
      expBusy = 2 * (lastIdx + 1) + nHit + (died ? 0 : 1);
   endtask

   // One frame tick and the whole resulting scan, checked against the model
   task automatic applyStimulus(input string name);
      if (modelGameOver) begin
         modelTick();
         expBusy = 0;
         expPulses = 0;
      end else begin
         modelTick();
         modelScan();
      end
      busyCnt = 0;
      pulseCnt = 0;
      tick = 1'b1;
      stepCycle();
      tick = 1'b0;
      for (int c = 0; c < 60 && busy; c++) stepCycle();
      if (busy !== 1'b0) checkOutput({name, "_timeout"}, 32'(busy), 32'd0);
      stepCycle();
      stepCycle();
      checkOutput({name, "_hp"}, 32'(hp), 32'(modelHp));
      checkOutput({name, "_game_over"}, 32'(game_over), 32'(modelGameOver));
      checkOutput({name, "_hit_pulses"}, 32'(pulseCnt), 32'(expPulses));
      checkOutput({name, "_busy_cycles"}, 32'(busyCnt), 32'(expBusy));
      checkOutput({name, "_missing_collides"}, 32'(expIdxQ.size()), 32'd0);
      expIdxQ.delete();
   endtask

   initial begin
      clearTable();
      modelHp = 20;
      modelInvuln = 0;
      modelGameOver = 1'b0;
      setPlayer(45, 45, 10, 10);
      rst_n = 1'b0;
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
      checkOutput("reset_hp", 32'(hp), 32'd20);
      checkOutput("reset_game_over", 32'(game_over), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_is_collide", 32'(is_collide), 32'd0);
      checkOutput("reset_bullet_index", 32'(bullet_index), 32'd0);

      loadSlot(0, 40, 40, 16, 16, 0);
      applyStimulus("single_hit");

      loadSlot(0, 40, 40, 16, 16, 0);
      setPlayer(56, 45, 10, 10);
      applyStimulus("edge_touch");

      loadSlot(0, 250, 40, 16, 16, 0);
      setPlayer(5, 45, 10, 10);
      applyStimulus("wrap_far");

      setPlayer(252, 45, 10, 10);
      applyStimulus("wrap_near_edge");

      clearTable();
      setPlayer(45, 45, 10, 10);
      applyStimulus("empty_a");
      applyStimulus("empty_b");

      loadSlot(0, 40, 40, 16, 16, 0);
      applyStimulus("white_first");
      loadSlot(1, 40, 40, 16, 16, 0);
      applyStimulus("white_invuln");

      loadSlot(3, 44, 44, 4, 4, 1);
      applyStimulus("green_heal");

      loadSlot(2, 50, 50, 8, 8, 2);
      player_moving = 1'b0;
      applyStimulus("blue_still");
      player_moving = 1'b1;
      applyStimulus("blue_moving");
      player_moving = 1'b0;

      clearTable();
      busyRises = 0;
      tick = 1'b1;
      stepCycle();
      tick = 1'b0;
      modelTick();
      repeat (4) stepCycle();
      tick = 1'b1;
      stepCycle();
      tick = 1'b0;
      modelTick();
      repeat (3) stepCycle();
      tick = 1'b1;
      stepCycle();
      tick = 1'b0;
      modelTick();
      repeat (60) stepCycle();
      checkOutput("pending_scan_count", 32'(busyRises), 32'd2);
      checkOutput("pending_busy_end", 32'(busy), 32'd0);
      checkOutput("pending_hp", 32'(hp), 32'(modelHp));

      expIdxQ.delete();
      loadSlot(7, 40, 40, 16, 16, 0);
      tick = 1'b1;
      stepCycle();
      tick = 1'b0;
      repeat (5) stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_hp", 32'(hp), 32'd20);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_is_collide", 32'(is_collide), 32'd0);
      checkOutput("midreset_bullet_index", 32'(bullet_index), 32'd0);
      checkOutput("midreset_game_over", 32'(game_over), 32'd0);
      stepCycle();
      rst_n = 1'b1;
      modelHp = 20;
      modelInvuln = 0;
      modelGameOver = 1'b0;
      collideCnt = 0;
      repeat (30) stepCycle();
      checkOutput("midreset_no_collide", 32'(collideCnt), 32'd0);
      checkOutput("midreset_stays_idle", 32'(busy), 32'd0);

      clearTable();
      loadSlot(0, 40, 40, 16, 16, 1);
      applyStimulus("green_at_max");

      while (modelHp > 1) begin
         loadSlot(0, 40, 40, 16, 16, 0);
         applyStimulus("drain_hit");
         applyStimulus("drain_gap_a");
         applyStimulus("drain_gap_b");
      end
      loadSlot(0, 40, 40, 16, 16, 0);
      loadSlot(4, 40, 40, 16, 16, 0);
      applyStimulus("death_hit");
      applyStimulus("after_death");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
